fetcher: RTL and testbench
==========================

Name: fetcher

Overview:
- Instruction fetch stage for one compute unit; sits directly upstream of the CU scheduler and decoder.
- When the scheduler enters FETCH, the block reads the instruction at curr_pc from program memory over a valid/ready handshake.
- It registers the instruction for the decoder and reports its progress on fetch_state, which the scheduler polls to leave FETCH.

Parameters:
- PC_ADDR_WIDTH, 8, program-memory address width; must match scheduler curr_pc.
- INSTR_WIDTH, 16, instruction word width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0); deassertion synchronous to clk by integration.
- cu_state  input  4  scheduler state: IDLE=0, FETCH=1, DECODE=2 … DONE=7.
- curr_pc  input  PC_ADDR_WIDTH  PC to fetch, from scheduler.
- mem_read_valid  output  1  request valid to program memory.
- mem_read_addr  output  PC_ADDR_WIDTH  request address.
- mem_read_ready  input  1  memory response strobe; data valid in the same cycle.
- mem_read_data  input  INSTR_WIDTH  instruction word.
- fetch_state  output  2  FT_IDLE=0, FT_REQ=1, FT_WAIT=2, FT_DONE=3.
- instruction  output  INSTR_WIDTH  registered instruction to decoder.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_state=FT_IDLE, mem_read_valid=0, mem_read_addr=0, instruction=0.
  - Reset may assert in any state; the in-flight request is dropped and no capture occurs.
- All outputs are registered; no combinational path from input to output.
- FT_IDLE:
  - If cu_state==FETCH: latch mem_read_addr<=curr_pc, set mem_read_valid<=1, go to FT_REQ.
  - Otherwise hold.
- FT_REQ:
  - mem_read_valid=1.
  - If mem_read_ready: instruction<=mem_read_data, mem_read_valid<=0, go to FT_DONE.
  - Else go to FT_WAIT.
- FT_WAIT:
  - mem_read_valid held 1 and mem_read_addr held stable until mem_read_ready.
  - On ready: capture data, drop valid, go to FT_DONE.
  - No timeout; an unbounded wait is legal.
- FT_DONE:
  - instruction held stable.
  - Leave to FT_IDLE when cu_state==DECODE (the scheduler sees FT_DONE, moves to DECODE next cycle, and the fetcher releases one cycle later).
  - instruction keeps its value until the next capture; the decoder may sample it for the rest of the instruction.
- Minimum latency: curr_pc to FT_DONE is 3 clocks with a zero-wait memory (IDLE→REQ, REQ→DONE, plus the scheduler FETCH entry cycle).
- Abort: cu_state==IDLE in any state forces FT_IDLE and mem_read_valid<=0 the next cycle, with no capture. Memory must tolerate valid dropping before ready.
- mem_read_ready while mem_read_valid=0 is ignored.
- curr_pc changing while in FT_REQ/FT_WAIT is ignored; the latched address is used.
- Addresses wrap naturally at 2^PC_ADDR_WIDTH; there is no range check.

Optional Feature:
- Macro: FETCH_CACHE_EN.
- Enabled:
  - Single-entry instruction buffer: tag register (PC_ADDR_WIDTH bits), data register, buf_valid.
  - Filled on every memory capture.
  - In FT_IDLE with cu_state==FETCH, buf_valid, and tag==curr_pc: instruction<=buffered data, go directly to FT_DONE, no memory request (mem_read_valid stays 0).
  - buf_valid cleared on reset and whenever cu_state==DONE (kernel end).
- Disabled: every fetch goes to memory; no buffer registers exist.

Decomposition:
- Shared package minigpu_pkg holds:
  - CU state encodings (IDLE..DONE).
  - Fetcher state encodings (FT_IDLE..FT_DONE).
  - Default widths, so the fetcher and scheduler use one definition.
- Single module by default. With FETCH_CACHE_EN, the tag/data/valid buffer is a natural sub-module, fetch_line_buf.

Test Plan:
- Zero-wait read: curr_pc=8'h05, cu_state=1, memory returns 16'hA1B2 with ready on first valid cycle → valid high 1 cycle, addr=05, FT_DONE next cycle, instruction=A1B2.
- Wait states: ready delayed 4 cycles → FT_WAIT for 3 cycles, valid/addr stable throughout, capture 16'h3C00 then FT_DONE; FT_IDLE one cycle after cu_state=2.
- Abort: cu_state forced 0 while in FT_WAIT → next cycle FT_IDLE, valid=0, instruction unchanged; a late ready pulse causes no capture.
- Reset mid-fetch: reset=0 asynchronously in FT_REQ → immediately fetch_state=0, valid=0, instruction=0 without waiting for a clock edge.
- PC wrap: curr_pc=8'hFF, then scheduler next_pc=8'h00 → second fetch issues addr 00 correctly.
- FETCH_CACHE_EN: fetch 8'h10 twice in a row → second fetch shows no valid pulse and reaches FT_DONE the cycle after FETCH. After cu_state=7 then refetch 8'h10 → memory request issued.

Source files
------------

// File: rtl/minigpu_pkg.sv
// Shared compute-unit encodings and default widths for the scheduler and fetcher.
// No logic; constants only.
// No handshake; consumers apply their own flow control.
package minigpu_pkg;

    localparam int PC_ADDR_WIDTH_DEF = 8;
    localparam int INSTR_WIDTH_DEF   = 16;

    // Scheduler (cu_state) encodings
    localparam logic [3:0] CU_IDLE   = 4'd0;
    localparam logic [3:0] CU_FETCH  = 4'd1;
    localparam logic [3:0] CU_DECODE = 4'd2;
    localparam logic [3:0] CU_DONE   = 4'd7;

    // Fetcher progress encodings, polled by the scheduler
    localparam logic [1:0] FT_IDLE = 2'd0;
    localparam logic [1:0] FT_REQ  = 2'd1;
    localparam logic [1:0] FT_WAIT = 2'd2;
    localparam logic [1:0] FT_DONE = 2'd3;

endpackage

// File: rtl/fetch_line_buf.sv
// Single-entry tag/data buffer holding the last instruction fetched from memory.
// Fill visible one cycle after the fill strobe; lookup hit is combinational.
// No backpressure; fill and clear are accepted every cycle, clear wins.
`ifdef FETCH_CACHE_EN
module fetch_line_buf
    import minigpu_pkg::*;
#(
    parameter int TAG_W = PC_ADDR_WIDTH_DEF,
    parameter int DAT_W = INSTR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             fill_vld_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [DAT_W-1:0] fill_dat_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [DAT_W-1:0] dat_o
);

    logic             buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [DAT_W-1:0] dat_q, dat_d;

    always_comb begin
        buf_valid_d = buf_valid_q;
        tag_d       = tag_q;
        dat_d       = dat_q;
        if (fill_vld_i) begin
            buf_valid_d = 1'b1;
            tag_d       = fill_tag_i;
            dat_d       = fill_dat_i;
        end
        if (clear_i) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            tag_q       <= '0;
            dat_q       <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            tag_q       <= tag_d;
            dat_q       <= dat_d;
        end
    end

    assign hit_o = buf_valid_q && (tag_q == lookup_tag_i);
    assign dat_o = dat_q;

endmodule
`endif

// File: rtl/fetcher.sv
// Instruction fetch stage: reads curr_pc from program memory on scheduler FETCH (FETCH_CACHE_EN adds a one-entry buffer).
// Latency: FT_DONE two edges after FETCH with zero-wait memory (one edge on a buffer hit).
// Backpressure: holds valid/addr until mem_read_ready, unbounded; cu_state==IDLE aborts.
module fetcher
    import minigpu_pkg::*;
#(
    parameter int PC_ADDR_WIDTH = PC_ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH   = INSTR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               cu_state,
    input  logic [PC_ADDR_WIDTH-1:0] curr_pc,
    output logic                     mem_read_valid,
    output logic [PC_ADDR_WIDTH-1:0] mem_read_addr,
    input  logic                     mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]   mem_read_data,
    output logic [1:0]               fetch_state,
    output logic [INSTR_WIDTH-1:0]   instruction
);

    logic [1:0]               state_q, state_d;
    logic                     valid_q, valid_d;
    logic [PC_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     capture;
    logic                     buf_hit;
    logic [INSTR_WIDTH-1:0]   buf_dat;

    // Ready only counts while a request is outstanding and not being aborted
    assign capture = ((state_q == FT_REQ) || (state_q == FT_WAIT))
                     && mem_read_ready && (cu_state != CU_IDLE);

`ifdef FETCH_CACHE_EN
    fetch_line_buf #(
        .TAG_W (PC_ADDR_WIDTH),
        .DAT_W (INSTR_WIDTH)
    ) u_line_buf (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (cu_state == CU_DONE),
        .fill_vld_i   (capture),
        .fill_tag_i   (addr_q),
        .fill_dat_i   (mem_read_data),
        .lookup_tag_i (curr_pc),
        .hit_o        (buf_hit),
        .dat_o        (buf_dat)
    );
`else
    assign buf_hit = 1'b0;
    assign buf_dat = '0;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        if (cu_state == CU_IDLE) begin
            state_d = FT_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                FT_IDLE: begin
                    if (cu_state == CU_FETCH) begin
                        if (buf_hit) begin
                            instr_d = buf_dat;
                            state_d = FT_DONE;
                        end else begin
                            addr_d  = curr_pc;
                            valid_d = 1'b1;
                            state_d = FT_REQ;
                        end
                    end
                end
                FT_REQ, FT_WAIT: begin
                    if (capture) begin
                        instr_d = mem_read_data;
                        valid_d = 1'b0;
                        state_d = FT_DONE;
                    end else begin
                        state_d = FT_WAIT;
                    end
                end
                FT_DONE: begin
                    if (cu_state == CU_DECODE) begin
                        state_d = FT_IDLE;
                    end
                end
                default: begin
                    state_d = FT_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FT_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    assign fetch_state    = state_q;
    assign mem_read_valid = valid_q;
    assign mem_read_addr  = addr_q;
    assign instruction    = instr_q;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: scheduler/memory driver plus an instruction scoreboard.
module tb_fetcher;
    import minigpu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  cu_state;
    logic [7:0]  curr_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_addr;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [1:0]  fetch_state;
    logic [15:0] instruction;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [1:0]  prev_state = FT_IDLE;

    fetcher #(.PC_ADDR_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .cu_state       (cu_state),
        .curr_pc        (curr_pc),
        .mem_read_valid (mem_read_valid),
        .mem_read_addr  (mem_read_addr),
        .mem_read_ready (mem_read_ready),
        .mem_read_data  (mem_read_data),
        .fetch_state    (fetch_state),
        .instruction    (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every entry into FT_DONE must deliver the next expected instruction
    always @(negedge clk) begin
        if (reset && fetch_state == FT_DONE && prev_state != FT_DONE) begin
            check("done_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) check("instr", {16'd0, instruction}, {16'd0, exp_q.pop_front()});
        end
        prev_state = fetch_state;
    end

    // Full fetch through memory; ready arrives after wait_n FT_WAIT cycles
    task automatic fetch(input logic [7:0] pc, input logic [15:0] dat, input int wait_n);
        @(negedge clk);
        cu_state = CU_FETCH;
        curr_pc  = pc;
        exp_q.push_back(dat);
        @(negedge clk);
        check("req_state", {30'd0, fetch_state}, {30'd0, FT_REQ});
        check("req_valid", {31'd0, mem_read_valid}, 32'd1);
        check("req_addr", {24'd0, mem_read_addr}, {24'd0, pc});
        curr_pc = pc ^ 8'h5A;
        for (int i = 0; i < wait_n; i++) begin
            mem_read_data = 16'($urandom);
            @(negedge clk);
            check("wait_state", {30'd0, fetch_state}, {30'd0, FT_WAIT});
            check("wait_valid", {31'd0, mem_read_valid}, 32'd1);
            check("wait_addr", {24'd0, mem_read_addr}, {24'd0, pc});
        end
        mem_read_ready = 1'b1;
        mem_read_data  = dat;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = 16'($urandom);
        check("done_state", {30'd0, fetch_state}, {30'd0, FT_DONE});
        check("done_valid", {31'd0, mem_read_valid}, 32'd0);
        cu_state = CU_DECODE;
        @(negedge clk);
        check("release_state", {30'd0, fetch_state}, {30'd0, FT_IDLE});
        check("hold_instr", {16'd0, instruction}, {16'd0, dat});
        cu_state = 4'd3;
    endtask

    initial begin
        reset          = 1'b0;
        cu_state       = CU_IDLE;
        curr_pc        = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        #12;
        check("rst_state", {30'd0, fetch_state}, {30'd0, FT_IDLE});
        check("rst_valid", {31'd0, mem_read_valid}, 32'd0);
        check("rst_addr", {24'd0, mem_read_addr}, 32'd0);
        check("rst_instr", {16'd0, instruction}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait and wait-state reads
        fetch(8'h05, 16'hA1B2, 0);
        fetch(8'h22, 16'h3C00, 3);

        // Abort from FT_WAIT, then a stray ready must not capture
        @(negedge clk);
        cu_state = CU_FETCH;
        curr_pc  = 8'h30;
        @(negedge clk);
        @(negedge clk);
        check("abort_pre", {30'd0, fetch_state}, {30'd0, FT_WAIT});
        cu_state = CU_IDLE;
        @(negedge clk);
        check("abort_state", {30'd0, fetch_state}, {30'd0, FT_IDLE});
        check("abort_valid", {31'd0, mem_read_valid}, 32'd0);
        check("abort_instr", {16'd0, instruction}, 32'h3C00);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        @(negedge clk);
        mem_read_ready = 1'b0;
        @(negedge clk);
        check("late_ready_instr", {16'd0, instruction}, 32'h3C00);
        check("late_ready_state", {30'd0, fetch_state}, {30'd0, FT_IDLE});

        // Asynchronous reset while a request is outstanding
        cu_state = CU_FETCH;
        curr_pc  = 8'h40;
        @(negedge clk);
        check("pre_rst_state", {30'd0, fetch_state}, {30'd0, FT_REQ});
        #2 reset = 1'b0;
        #1;
        check("arst_state", {30'd0, fetch_state}, {30'd0, FT_IDLE});
        check("arst_valid", {31'd0, mem_read_valid}, 32'd0);
        check("arst_addr", {24'd0, mem_read_addr}, 32'd0);
        check("arst_instr", {16'd0, instruction}, 32'd0);
        cu_state = CU_IDLE;
        @(negedge clk);
        reset = 1'b1;

        // Address wrap
        fetch(8'hFF, 16'h1111, 0);
        fetch(8'h00, 16'h2222, 1);

`ifdef FETCH_CACHE_EN
        fetch(8'h10, 16'h5A5A, 0);
        @(negedge clk);
        cu_state = CU_FETCH;
        curr_pc  = 8'h10;
        exp_q.push_back(16'h5A5A);
        @(negedge clk);
        check("hit_state", {30'd0, fetch_state}, {30'd0, FT_DONE});
        check("hit_valid", {31'd0, mem_read_valid}, 32'd0);
        cu_state = CU_DECODE;
        @(negedge clk);
        cu_state = CU_DONE;
        @(negedge clk);
        fetch(8'h10, 16'h6B6B, 0);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
